// File: rtl/pc_stack_pkg.sv
// Shared constants and helpers for the program-counter / return-stack block.
package pc_stack_pkg;

    localparam int WORD_W        = 16;
    localparam int DEFAULT_DEPTH = 4;

    // Width of a counter that must hold 0..d inclusive.
    function automatic int depth_w(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/pc_stack_lifo.sv
// Return-address LIFO: storage, depth counter, full/empty.
// Storage is unreset; entries above depth-1 are never read out.
module pc_stack_lifo
    import pc_stack_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int DW = depth_w(DEPTH),
    localparam int AW = DW - 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] top,
    output logic [DW-1:0]     depth,
    output logic              empty,
    output logic              full
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     wr_idx;
    logic              do_replace;
    logic              do_push;
    logic              do_pop;

    assign empty = (depth == '0);
    assign full  = (depth == DW'(DEPTH));

    // DEPTH is a power of two, so the low bits of depth wrap to DEPTH-1 when full.
    assign top_idx = depth[AW-1:0] - AW'(1);
    assign wr_idx  = depth[AW-1:0];
    assign top     = mem[top_idx];

    // Push+pop on a non-empty stack swaps the top in place; push+pop on an
    // empty stack degrades to a plain push.
    assign do_replace = !clear && push && pop && !empty;
    assign do_push    = !clear && push && !full && !(pop && !empty);
    assign do_pop     = !clear && pop && !empty && !push;

    // Entry writes: replace-top or append.
    always_ff @(posedge clock) begin
        if (do_replace) begin
            mem[top_idx] <= wr_data;
        end else if (do_push) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Depth counter; clear empties the stack.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            depth <= '0;
        end else if (clear) begin
            depth <= '0;
        end else if (do_push) begin
            depth <= depth + DW'(1);
        end else if (do_pop) begin
            depth <= depth - DW'(1);
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with return-address stack and sticky overflow/underflow flags.
// PC priority: clear > load > pop (non-empty) > inc > hold.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [WORD_W-1:0]         in,
    input  logic                      load,
    input  logic                      inc,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    output logic [WORD_W-1:0]         out,
    output logic [depth_w(DEPTH)-1:0] depth,
    output logic                      empty,
    output logic                      full,
    output logic                      overflow,
    output logic                      underflow
);

    logic [WORD_W-1:0] top;
    logic [WORD_W-1:0] pc_next;
    logic [WORD_W-1:0] ret_addr;
    logic              pop_taken;

    assign ret_addr  = out + WORD_W'(1);
    assign pop_taken = pop && !empty;

    pc_stack_lifo #(.DEPTH(DEPTH)) u_lifo (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .wr_data (ret_addr),
        .top     (top),
        .depth   (depth),
        .empty   (empty),
        .full    (full)
    );

    // Next-PC priority mux.
    always_comb begin
        pc_next = out;
        if (clear) begin
            pc_next = '0;
        end else if (load) begin
            pc_next = in;
        end else if (pop_taken) begin
            pc_next = top;
        end else if (inc) begin
            pc_next = ret_addr;
        end
    end

    // PC register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out <= '0;
        end else begin
            out <= pc_next;
        end
    end

    // Sticky error flags; only clear or reset drops them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full && !pop) overflow <= 1'b1;
            if (pop && empty) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: directed vectors feed an expected queue, a negedge
// monitor pops and compares against the registered outputs.
module tb_pc_stack;

    localparam int EW = 16 + 3 + 4;

    logic        clock;
    logic        reset_n;
    logic [15:0] in;
    logic        load;
    logic        inc;
    logic        clear;
    logic        push;
    logic        pop;
    logic [15:0] out;
    logic [2:0]  depth;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    logic [EW-1:0] exp_q[$];
    int            n_checks;
    int            n_fail;
    int            vec_id;

    pc_stack #(.DEPTH(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in        (in),
        .load      (load),
        .inc       (inc),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .out       (out),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, %0d checks outstanding", exp_q.size());
        n_fail = n_fail + 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    function automatic logic [EW-1:0] pack_exp(input logic [15:0] e_out, input int e_depth,
                                               input logic e_ovf, input logic e_unf);
        return {e_out, 3'(e_depth), (e_depth == 0), (e_depth == 4), e_ovf, e_unf};
    endfunction

    // Scoreboard monitor: compare one queued expectation per falling edge.
    initial begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        vec_id = 0;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {out, depth, empty, full, overflow, underflow};
                n_checks = n_checks + 1;
                if (a !== e) begin
                    n_fail = n_fail + 1;
                    $display("FAIL vec%0d: got out=%h depth=%0d e=%b f=%b ovf=%b unf=%b, want out=%h depth=%0d e=%b f=%b ovf=%b unf=%b",
                             vec_id, a[22:7], a[6:4], a[3], a[2], a[1], a[0],
                             e[22:7], e[6:4], e[3], e[2], e[1], e[0]);
                end
                vec_id = vec_id + 1;
            end
        end
    end

    // Driver: apply one cycle of controls and queue the hand-computed result.
    task automatic step(input logic ld, input logic ic, input logic cl, input logic ps,
                        input logic pp, input logic [15:0] din, input logic [15:0] e_out,
                        input int e_depth, input logic e_ovf, input logic e_unf);
        load  = ld;
        inc   = ic;
        clear = cl;
        push  = ps;
        pop   = pp;
        in    = din;
        @(posedge clock);
        #1;
        exp_q.push_back(pack_exp(e_out, e_depth, e_ovf, e_unf));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        in = '0; load = 0; inc = 0; clear = 0; push = 0; pop = 0;

        // Reset state.
        #2;
        exp_q.push_back(pack_exp(16'h0000, 0, 0, 0));
        @(negedge clock);
        #2 reset_n = 1'b1;

        //    ld ic cl ps pp  in        out       d  ovf unf
        step(0, 1, 0, 0, 0, 16'h0000, 16'h0001, 0, 0, 0);
        step(0, 1, 0, 0, 0, 16'h0000, 16'h0002, 0, 0, 0);
        step(0, 1, 0, 0, 0, 16'h0000, 16'h0003, 0, 0, 0);
        // Call via load+push, then return.
        step(1, 0, 0, 0, 0, 16'h0010, 16'h0010, 0, 0, 0);
        step(1, 0, 0, 1, 0, 16'h0200, 16'h0200, 1, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0000, 16'h0011, 0, 0, 0);
        // Fill to full, then overflow.
        step(0, 1, 0, 1, 0, 16'h0000, 16'h0012, 1, 0, 0);
        step(0, 1, 0, 1, 0, 16'h0000, 16'h0013, 2, 0, 0);
        step(0, 1, 0, 1, 0, 16'h0000, 16'h0014, 3, 0, 0);
        step(0, 1, 0, 1, 0, 16'h0000, 16'h0015, 4, 0, 0);
        step(0, 1, 0, 1, 0, 16'h0000, 16'h0016, 4, 1, 0);
        // Drain LIFO, then underflow.
        step(0, 0, 0, 0, 1, 16'h0000, 16'h0015, 3, 1, 0);
        step(0, 0, 0, 0, 1, 16'h0000, 16'h0014, 2, 1, 0);
        step(0, 0, 0, 0, 1, 16'h0000, 16'h0013, 1, 1, 0);
        step(0, 0, 0, 0, 1, 16'h0000, 16'h0012, 0, 1, 0);
        step(0, 1, 0, 0, 1, 16'h0000, 16'h0013, 0, 1, 1);
        step(0, 0, 0, 0, 1, 16'h0000, 16'h0013, 0, 1, 1);
        step(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        // Wrap of PC and of the saved return address.
        step(1, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        step(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        step(1, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        step(0, 0, 0, 1, 0, 16'h0000, 16'hFFFF, 1, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
        // Simultaneous push+pop replaces top.
        step(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
        step(1, 0, 0, 0, 0, 16'h004F, 16'h004F, 1, 0, 0);
        step(0, 0, 0, 1, 0, 16'h0000, 16'h004F, 2, 0, 0);
        step(1, 0, 0, 0, 0, 16'h0100, 16'h0100, 2, 0, 0);
        step(0, 0, 0, 1, 1, 16'h0000, 16'h0050, 2, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0000, 16'h0101, 1, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0000, 16'h0001, 0, 0, 0);
        // Push+pop on empty: underflow, push still lands, PC holds.
        step(0, 0, 0, 1, 1, 16'h0000, 16'h0001, 1, 0, 1);
        step(0, 0, 0, 0, 1, 16'h0000, 16'h0002, 0, 0, 1);
        // Clear beats load/push/inc.
        step(1, 0, 0, 0, 0, 16'h0123, 16'h0123, 0, 0, 1);
        step(1, 1, 1, 1, 0, 16'h5555, 16'h0000, 0, 0, 0);
        // Load beats pop, but the stack still pops.
        step(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
        step(1, 0, 0, 0, 1, 16'h0777, 16'h0777, 0, 0, 0);
        step(0, 1, 0, 0, 1, 16'h0000, 16'h0778, 0, 0, 1);

        // Reset pulsed between edges while a push is in flight.
        step(1, 0, 0, 1, 0, 16'h0AAA, 16'h0AAA, 1, 0, 1);
        load = 0; inc = 0; clear = 0; pop = 0; push = 1;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        push    = 1'b0;
        exp_q.push_back(pack_exp(16'h0000, 0, 0, 0));
        @(negedge clock);
        #1 reset_n = 1'b1;
        // Nothing retained: pop sees an empty stack.
        step(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1);

        load = 0; inc = 0; clear = 0; push = 0; pop = 0;
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
        @(posedge clock);
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter: DEPTH, 4, number of return-address entries (power of two, 2..16).
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous reset, active-low.
REQ-004 Port: in  input  16  jump target, loaded when load=1.
REQ-005 Port: load  input  1  load PC from in.
REQ-006 Port: inc  input  1  increment PC.
REQ-007 Port: clear  input  1  synchronous restart; PC := 0, stack emptied.
REQ-008 Port: push  input  1  call: save return address (out+1) on stack.
REQ-009 Port: pop  input  1  return: PC := top of stack, stack shrinks by one.
REQ-010 Port: out  output  16  current PC, registered.
REQ-011 Port: depth  output  $clog2(DEPTH)+1  valid entries on stack, registered.
REQ-012 Port: empty, full  output  1 each  depth==0 / depth==DEPTH, combinational from depth.
REQ-013 Port: overflow, underflow  output  1 each  sticky error flags, registered.

Function
REQ-014 PC next-value priority, evaluated each rising edge: clear > load > pop (only when non-empty) > inc > hold.
REQ-015 clear: out := 0x0000, depth := 0, overflow := 0, underflow := 0; all other inputs ignored that cycle.
REQ-016 load: out := in on the same edge; latency one clock; no combinational path from inputs to out.
REQ-017 inc: out := out + 1 modulo 2^16; 0xFFFF wraps to 0x0000, no flag.
REQ-018 push, not full: stack[depth] := out + 1 (mod 2^16), depth += 1; independent of which PC update is selected.
REQ-019 push, full, no simultaneous pop: stack and depth unchanged, overflow := 1.
REQ-020 pop, non-empty, no push: out := stack[depth-1], depth -= 1, unless clear or load takes priority, in which case the stack still pops.
REQ-021 pop, empty: underflow := 1, stack unchanged, PC follows inc/hold rule.
REQ-022 push and pop together, non-empty: out := old top (unless clear/load), top entry replaced by old out + 1, depth unchanged, no flag (full or not).
REQ-023 push and pop together, empty: underflow := 1, push executes per REQ-018.
REQ-024 overflow and underflow remain set until clear or reset_n.
REQ-025 Entries above depth-1 are don't-care and never observable at out.

Reset
REQ-026 reset_n low asynchronously forces out=0x0000, depth=0, overflow=0, underflow=0, regardless of clock.
REQ-027 reset_n deassertion is sampled synchronously; first state change occurs on the first rising edge with reset_n high.
REQ-028 Stack storage needs no reset; REQ-025 guarantees no X reaches out.
REQ-029 Reset asserted mid-push/pop aborts the operation; no partial update is visible after release.

Structure
REQ-030 Shared package pc_stack_pkg holds WORD_W=16, DEFAULT_DEPTH=4, and the depth-width function/constant.
REQ-031 One sub-module, pc_stack_lifo: DEPTH x 16 storage with push/pop/replace-top controls, depth counter, full/empty; pc_stack owns the PC register, priority mux and sticky flags.
REQ-032 All state updates occur on rising clock; only empty/full are combinational.

Verification
REQ-033 Reset then inc x3 -> out 0x0000,0x0001,0x0002,0x0003; depth 0, empty=1.
REQ-034 out=0x0010, load=1 in=0x0200 push=1 -> out=0x0200, depth=1, top=0x0011; next pop=1 -> out=0x0011, depth=0.
REQ-035 Five pushes with DEPTH=4 -> full=1 after fourth, overflow=1 after fifth, depth stays 4; four pops return entries LIFO, fifth pop sets underflow=1, out holds/incs.
REQ-036 out=0xFFFF, inc=1 -> out=0x0000; push at out=0xFFFF stores 0x0000.
REQ-037 depth=2 top=0x0050, out=0x0100, push=1 pop=1 -> out=0x0050, depth=2, top=0x0101; then clear=1 with load=1 -> out=0x0000, depth=0, flags 0.
REQ-038 reset_n pulsed low between clock edges during push -> out=0, depth=0 immediately, flags 0, no entry retained.
